// File: rtl/canright_pkg.sv
// Composite-field GF(((2^2)^2)^2) arithmetic and the basis-change matrices for the
// Canright AES S-box. The matrices are derived at elaboration from the field definitions.
package canright_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned NIB_W       = 4;
    localparam int unsigned PAIR_W      = 2;
    localparam int unsigned LOAD_BIT    = 0;
    localparam int unsigned CAPTURE_BIT = 1;
    localparam int unsigned INV_BIT     = 2;

    localparam logic [BYTE_W-1:0] AFFINE_C = 8'h63;

    // Normal-basis constants: GF(4) uses {W^2, W}, so the field element 1 is all-ones.
    localparam logic [PAIR_W-1:0] GF4_N     = 2'b10;
    localparam logic [BYTE_W-1:0] GF256_ONE = 8'hFF;

    // Column j holds the image of input bit j.
    typedef logic [BYTE_W-1:0][BYTE_W-1:0] mat8_t;

    function automatic logic [PAIR_W-1:0] gf4_mul(logic [PAIR_W-1:0] a, logic [PAIR_W-1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {e ^ (a[1] & b[1]), e ^ (a[0] & b[0])};
    endfunction

    function automatic logic [PAIR_W-1:0] gf4_sq(logic [PAIR_W-1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [PAIR_W-1:0] gf4_scale_n(logic [PAIR_W-1:0] a);
        return gf4_mul(a, GF4_N);
    endfunction

    function automatic logic [NIB_W-1:0] gf16_mul(logic [NIB_W-1:0] a, logic [NIB_W-1:0] b);
        logic [PAIR_W-1:0] se;
        se = gf4_scale_n(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {gf4_mul(a[3:2], b[3:2]) ^ se, gf4_mul(a[1:0], b[1:0]) ^ se};
    endfunction

    // Smallest nu making Y^2 + Y + nu irreducible over GF(16): nu outside the image of y^2+y.
    function automatic logic [NIB_W-1:0] find_nu();
        logic [NIB_W-1:0] r;
        logic             found;
        logic             ok;
        r     = '0;
        found = 1'b0;
        for (int n = 1; n < 16; n++) begin
            ok = 1'b1;
            for (int y = 0; y < 16; y++) begin
                if ((gf16_mul(4'(y), 4'(y)) ^ 4'(y)) == 4'(n)) ok = 1'b0;
            end
            if (ok && !found) begin
                r     = 4'(n);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    localparam logic [NIB_W-1:0] GF16_NU = find_nu();

    function automatic logic [BYTE_W-1:0] gf256_mul(logic [BYTE_W-1:0] a, logic [BYTE_W-1:0] b);
        logic [NIB_W-1:0] se;
        se = gf16_mul(gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]), GF16_NU);
        return {gf16_mul(a[7:4], b[7:4]) ^ se, gf16_mul(a[3:0], b[3:0]) ^ se};
    endfunction

    function automatic logic [BYTE_W-1:0] mat_apply(mat8_t m, logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ m[i];
        end
        return r;
    endfunction

    // Root of x^8+x^4+x^3+x+1 in the composite field; its powers span the polynomial basis.
    function automatic mat8_t build_in_fwd();
        mat8_t             p;
        mat8_t             r;
        logic [BYTE_W-1:0] sum;
        logic              found;
        r     = '0;
        p     = '0;
        found = 1'b0;
        for (int g = 1; g < 256; g++) begin
            p[0] = GF256_ONE;
            for (int i = 1; i < 8; i++) p[i] = gf256_mul(p[i-1], 8'(g));
            sum = gf256_mul(p[7], 8'(g)) ^ p[4] ^ p[3] ^ p[1] ^ p[0];
            if (sum == '0 && !found) begin
                r     = p;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic mat8_t mat_invert(mat8_t m);
        mat8_t r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            for (int a = 0; a < 256; a++) begin
                if (mat_apply(m, 8'(a)) == 8'(1 << j)) r[j] = 8'(a);
            end
        end
        return r;
    endfunction

    function automatic logic [BYTE_W-1:0] affine_fwd_lin(logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] r;
        logic [BYTE_W-1:0] t;
        r = x;
        t = x;
        for (int k = 1; k <= 4; k++) begin
            t = {t[6:0], t[7]};
            r = r ^ t;
        end
        return r;
    endfunction

    function automatic logic [BYTE_W-1:0] affine_inv_lin(logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] r;
        logic [BYTE_W-1:0] t;
        r = '0;
        t = x;
        for (int k = 1; k <= 6; k++) begin
            t = {t[6:0], t[7]};
            if (k == 1 || k == 3 || k == 6) r = r ^ t;
        end
        return r;
    endfunction

    function automatic mat8_t build_out_fwd(mat8_t out_inv);
        mat8_t r;
        for (int j = 0; j < 8; j++) r[j] = affine_fwd_lin(out_inv[j]);
        return r;
    endfunction

    function automatic mat8_t build_in_inv(mat8_t in_fwd);
        mat8_t r;
        for (int j = 0; j < 8; j++) r[j] = mat_apply(in_fwd, affine_inv_lin(8'(1 << j)));
        return r;
    endfunction

    localparam mat8_t MAT_IN_FWD  = build_in_fwd();
    localparam mat8_t MAT_OUT_INV = mat_invert(MAT_IN_FWD);
    localparam mat8_t MAT_OUT_FWD = build_out_fwd(MAT_OUT_INV);
    localparam mat8_t MAT_IN_INV  = build_in_inv(MAT_IN_FWD);

endpackage

// File: rtl/canright_sbox_if.sv
// Byte bus between the tile registers and the combinational inversion core.
interface canright_sbox_if;
    logic [7:0] data;
    logic       inv;
    logic [7:0] result;

    modport master (output data, output inv, input result);
    modport slave  (input data, input inv, output result);
endinterface

// File: rtl/gf256_inv_core.sv
// Combinational S-box / inverse S-box: basis change, composite-field inversion, basis change back.
module gf256_inv_core
    import canright_pkg::*;
(
    canright_sbox_if.slave bus
);

    logic [BYTE_W-1:0] basis_in;
    logic [NIB_W-1:0]  hi;
    logic [NIB_W-1:0]  lo;
    logic [NIB_W-1:0]  sum;
    logic [NIB_W-1:0]  delta;
    logic [NIB_W-1:0]  delta_inv;
    logic [PAIR_W-1:0] d_hi;
    logic [PAIR_W-1:0] d_lo;
    logic [PAIR_W-1:0] d_t;
    logic [PAIR_W-1:0] d_th;
    logic [BYTE_W-1:0] inv_c;

    // Inverse mode strips the affine constant first; the linear part is folded into the matrix.
    always_comb begin : to_normal
        basis_in = mat_apply(MAT_IN_FWD, bus.data);
        if (bus.inv) basis_in = mat_apply(MAT_IN_INV, bus.data ^ AFFINE_C);
    end

    always_comb begin : gf256_inverse
        hi    = basis_in[7:4];
        lo    = basis_in[3:0];
        sum   = hi ^ lo;
        delta = gf16_mul(gf16_mul(sum, sum), GF16_NU) ^ gf16_mul(hi, lo);

        // GF(16) inverse from GF(4) ops; GF(4) inversion is a bit swap.
        d_hi      = delta[3:2];
        d_lo      = delta[1:0];
        d_t       = gf4_scale_n(gf4_sq(d_hi ^ d_lo)) ^ gf4_mul(d_hi, d_lo);
        d_th      = gf4_sq(d_t);
        delta_inv = {gf4_mul(d_th, d_lo), gf4_mul(d_th, d_hi)};

        inv_c = {gf16_mul(delta_inv, lo), gf16_mul(delta_inv, hi)};
    end

    always_comb begin : from_normal
        bus.result = mat_apply(MAT_OUT_FWD, inv_c) ^ AFFINE_C;
        if (bus.inv) bus.result = mat_apply(MAT_OUT_INV, inv_c);
    end

endmodule

// File: rtl/canright_sbox.sv
// Tiny Tapeout tile: load register, combinational Canright S-box core, capture register.
module canright_sbox
    import canright_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    canright_sbox_if core_if ();

    logic [BYTE_W-1:0] in_q;
    logic [BYTE_W-1:0] in_d;
    logic              inv_q;
    logic              inv_d;
    logic [BYTE_W-1:0] out_q;
    logic [BYTE_W-1:0] out_d;
    logic              unused_sig;

    assign core_if.data = in_q;
    assign core_if.inv  = inv_q;

    gf256_inv_core u_core (
        .bus (core_if)
    );

    always_comb begin : next_state
        in_d  = in_q;
        inv_d = inv_q;
        out_d = out_q;
        if (uio_in[LOAD_BIT]) begin
            in_d  = ui_in;
            inv_d = uio_in[INV_BIT];
        end
        if (uio_in[CAPTURE_BIT]) out_d = core_if.result;
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            in_q  <= '0;
            inv_q <= 1'b0;
            out_q <= '0;
        end else begin
            in_q  <= in_d;
            inv_q <= inv_d;
            out_q <= out_d;
        end
    end

    assign uo_out     = out_q;
    assign uio_out    = 8'h00;
    assign uio_oe     = 8'h00;
    assign unused_sig = &{1'b0, ena, uio_in[7:3]};

endmodule

// File: tb/tb_canright_sbox.sv
// Directed self-checking bench for canright_sbox against an independent GF(2^8) reference.
module tb_canright_sbox;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    canright_sbox dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        logic [7:0] t;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        s = r;
        t = r;
        for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [7:0] x, input logic inv);
        ui_in  = x;
        uio_in = inv ? 8'h05 : 8'h01;
        step();
        uio_in = inv ? 8'h07 : 8'h03;
        step();
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ui_in  = 8'hA5;
        uio_in = 8'h00;
        step();
        step();
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL reset_uo_out got %02h want 00", uo_out); end
        n_cmp++;
        if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset_uio_out got %02h want 00", uio_out); end
        n_cmp++;
        if (uio_oe !== 8'h00) begin n_err++; $display("FAIL reset_uio_oe got %02h want 00", uio_oe); end
        rst_n = 1'b1;
        step();
        uio_in = 8'h02;
        step();
        uio_in = 8'h00;
        n_cmp++;
        if (uo_out !== 8'h63) begin n_err++; $display("FAIL capture_no_load got %02h want 63", uo_out); end
    endtask

    task automatic test_single();
        logic [7:0] ins  [3] = '{8'h00, 8'h53, 8'hFF};
        logic [7:0] outs [3] = '{8'h63, 8'hED, 8'h16};
        for (int i = 0; i < 3; i++) begin
            lookup(ins[i], 1'b0);
            n_cmp++;
            if (uo_out !== outs[i]) begin
                n_err++;
                $display("FAIL single_fwd in=%02h got %02h want %02h", ins[i], uo_out, outs[i]);
            end
        end
    endtask

    task automatic test_exhaustive_fwd();
        logic [7:0] exp_v;
        for (int i = 0; i < 256; i++) begin
            lookup(8'(i), 1'b0);
            exp_v = ref_sbox(8'(i));
            n_cmp++;
            if (uo_out !== exp_v) begin
                n_err++;
                $display("FAIL exh_fwd in=%02h got %02h want %02h", i[7:0], uo_out, exp_v);
            end
        end
    endtask

    task automatic test_inverse();
        lookup(8'h63, 1'b1);
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL inv_63 got %02h want 00", uo_out); end
        lookup(8'hED, 1'b1);
        n_cmp++;
        if (uo_out !== 8'h53) begin n_err++; $display("FAIL inv_ED got %02h want 53", uo_out); end
        for (int i = 0; i < 256; i++) begin
            lookup(ref_sbox(8'(i)), 1'b1);
            n_cmp++;
            if (uo_out !== 8'(i)) begin
                n_err++;
                $display("FAIL exh_inv in=%02h got %02h want %02h", ref_sbox(8'(i)), uo_out, i[7:0]);
            end
        end
    endtask

    task automatic test_hold();
        lookup(8'h00, 1'b0);
        uio_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            ui_in = 8'($urandom_range(0, 255));
            step();
            n_cmp++;
            if (uo_out !== 8'h63) begin
                n_err++;
                $display("FAIL hold cyc=%0d got %02h want 63", i, uo_out);
            end
        end
        ui_in  = 8'hFF;
        uio_in = 8'h02;
        step();
        uio_in = 8'h00;
        n_cmp++;
        if (uo_out !== 8'h63) begin n_err++; $display("FAIL hold_capture got %02h want 63", uo_out); end
    endtask

    task automatic test_back_to_back();
        ui_in  = 8'h53;
        uio_in = 8'h01;
        step();
        ui_in  = 8'hFF;
        uio_in = 8'h03;
        step();
        n_cmp++;
        if (uo_out !== 8'hED) begin n_err++; $display("FAIL b2b_first got %02h want ED", uo_out); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (uo_out !== 8'h16) begin
                n_err++;
                $display("FAIL b2b_stable cyc=%0d got %02h want 16", i, uo_out);
            end
        end
        uio_in = 8'h00;
    endtask

    task automatic test_async_reset();
        lookup(8'hFF, 1'b0);
        n_cmp++;
        if (uo_out !== 8'h16) begin n_err++; $display("FAIL pre_reset got %02h want 16", uo_out); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL async_reset got %02h want 00", uo_out); end
        rst_n = 1'b1;
        uio_in = 8'h02;
        step();
        uio_in = 8'h00;
        n_cmp++;
        if (uo_out !== 8'h63) begin n_err++; $display("FAIL post_reset_capture got %02h want 63", uo_out); end
    endtask

    initial begin
        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        test_reset();
        test_single();
        test_exhaustive_fwd();
        test_inverse();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
